// File: rtl/pix_pkg.sv
// pix_pkg: shared FSM states, RGB565 field layout and default frame geometry
// for the axis_pixel_packer slice.
package pix_pkg;
    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DISCARD} pix_state_t;
    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;
    localparam int PIX_W = R_W + G_W + B_W;
    localparam int B_OFF = 0;
    localparam int G_OFF = B_OFF + B_W;
    localparam int R_OFF = G_OFF + G_W;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
endpackage

// File: rtl/pix_byte_assembler.sv
// pix_byte_assembler: collects big-endian stream bytes into one RGB565 pixel,
// flagging completion on the final byte and dropping partial pixels on clear.
module pix_byte_assembler
    import pix_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              take,
    input  logic              first,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic              mid,
    output logic              done,
    output logic [R_W-1:0]    r,
    output logic [G_W-1:0]    g,
    output logic [B_W-1:0]    b
);
    localparam int IW = BYTES_PER_PIX > 1 ? $clog2(BYTES_PER_PIX) : 1;

    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_eff;
    logic [PIX_W-DATA_W-1:0] sh;
    logic [PIX_W-1:0]        word;

    // an SOF byte always restarts the pixel, whatever was collected before it
    assign idx_eff = first ? '0 : idx;
    assign done    = take && (idx_eff == IW'(BYTES_PER_PIX - 1));
    assign mid     = idx != '0;
    assign word    = {sh, data};
    assign r       = word[R_OFF +: R_W];
    assign g       = word[G_OFF +: G_W];
    assign b       = word[B_OFF +: B_W];

    always_ff @(posedge CLK) begin
        if (!RESETn || clear) begin
            idx <= '0;
            sh  <= '0;
        end else if (take) begin
            idx <= done ? '0 : idx_eff + IW'(1);
            sh  <= word[PIX_W-DATA_W-1:0];
        end
    end
endmodule

// File: rtl/axis_pixel_packer.sv
// axis_pixel_packer: byte-wide RGB565 AXI4-Stream to frame-buffer pixel writes,
// with line/frame tracking and error recovery; PIX_STATS_EN adds frame/error counters.
module axis_pixel_packer
    import pix_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int ADDR_W        = 19
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [DATA_W-1:0] S_TDATA,
    input  logic              S_TVALID,
    output logic              S_TREADY,
    input  logic              S_TLAST,
    input  logic              S_TUSER,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [R_W-1:0]    wr_r,
    output logic [G_W-1:0]    wr_g,
    output logic [B_W-1:0]    wr_b,
    output logic              frame_done,
    output logic              line_err,
`ifdef PIX_STATS_EN
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt,
`endif
    output logic              sync_lost
);
    localparam int XW = H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1;
    localparam int YW = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;

    pix_state_t        state, state_n;
    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic [ADDR_W-1:0] addr, addr_n, base, base_n;
    logic              wr_last;
    logic              acc, sof, last_x, last_y;
    logic              emit, last_n, le_n, sl_n, adv;
    logic              a_take, a_clear, a_mid, a_done;
    logic [R_W-1:0]    a_r;
    logic [G_W-1:0]    a_g;
    logic [B_W-1:0]    a_b;

    assign S_TREADY   = !wr_valid || wr_ready;
    assign frame_done = wr_valid && wr_ready && wr_last;
    assign acc        = S_TVALID && S_TREADY;
    assign sof        = acc && S_TUSER;
    assign last_x     = x == XW'(H_ACTIVE - 1);
    assign last_y     = y == YW'(V_ACTIVE - 1);
    assign a_take     = sof || (acc && state == ACTIVE);

    pix_byte_assembler #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX)
    ) u_asm (
        .CLK    (CLK),
        .RESETn (RESETn),
        .take   (a_take),
        .first  (sof),
        .clear  (a_clear),
        .data   (S_TDATA),
        .mid    (a_mid),
        .done   (a_done),
        .r      (a_r),
        .g      (a_g),
        .b      (a_b)
    );

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        addr_n  = addr;
        base_n  = base;
        emit    = 1'b0;
        last_n  = 1'b0;
        le_n    = 1'b0;
        sl_n    = 1'b0;
        adv     = 1'b0;
        a_clear = 1'b0;
        if (sof) begin
            sl_n    = state != WAIT_SOF && (x != '0 || y != '0 || a_mid);
            state_n = ACTIVE;
            x_n     = '0;
            y_n     = '0;
            addr_n  = '0;
            base_n  = '0;
        end else if (acc && state == ACTIVE) begin
            if (a_done) begin
                emit = 1'b1;
                if (last_x && S_TLAST) begin
                    adv    = 1'b1;
                    last_n = last_y;
                end else if (last_x) begin
                    le_n    = 1'b1;
                    state_n = DISCARD;
                end else if (S_TLAST) begin
                    le_n = 1'b1;
                    adv  = 1'b1;
                end else begin
                    x_n    = x + XW'(1);
                    addr_n = addr + ADDR_W'(1);
                end
            end else if (S_TLAST) begin
                le_n    = 1'b1;
                a_clear = 1'b1;
                adv     = 1'b1;
            end
        end else if (acc && state == DISCARD && S_TLAST) begin
            adv = 1'b1;
        end
        // line advance reloads the address from the running line base, so a
        // short line still lands the next pixel at the start of the next row
        if (adv) begin
            x_n     = '0;
            state_n = last_y ? WAIT_SOF : ACTIVE;
            y_n     = last_y ? '0 : y + YW'(1);
            base_n  = last_y ? '0 : base + ADDR_W'(H_ACTIVE);
            addr_n  = last_y ? '0 : base + ADDR_W'(H_ACTIVE);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state     <= WAIT_SOF;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            base      <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_r      <= '0;
            wr_g      <= '0;
            wr_b      <= '0;
            wr_last   <= 1'b0;
            line_err  <= 1'b0;
            sync_lost <= 1'b0;
        end else begin
            state     <= state_n;
            x         <= x_n;
            y         <= y_n;
            addr      <= addr_n;
            base      <= base_n;
            line_err  <= le_n;
            sync_lost <= sl_n;
            if (emit) begin
                wr_valid <= 1'b1;
                wr_addr  <= addr;
                wr_r     <= a_r;
                wr_g     <= a_g;
                wr_b     <= a_b;
                wr_last  <= last_n;
            end else if (wr_ready) begin
                wr_valid <= 1'b0;
            end
        end
    end

`ifdef PIX_STATS_EN
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_done && frame_cnt != 16'hFFFF)
                frame_cnt <= frame_cnt + 16'd1;
            if ((line_err || sync_lost) && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axis_pixel_packer.sv
// tb_axis_pixel_packer: directed frames on a 4x2 geometry with hand-computed
// write addresses, colours and error/frame pulses.
module tb_axis_pixel_packer;
    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic [7:0]  S_TDATA = '0;
    logic        S_TVALID = 1'b0;
    logic        S_TREADY;
    logic        S_TLAST = 1'b0;
    logic        S_TUSER = 1'b0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [2:0]  wr_addr;
    logic [4:0]  wr_r;
    logic [5:0]  wr_g;
    logic [4:0]  wr_b;
    logic        frame_done;
    logic        line_err;
    logic        sync_lost;
`ifdef PIX_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
`endif

    int checks = 0;
    int passes = 0;
    int n_fd = 0;
    int n_le = 0;
    int n_sl = 0;
    int wa[$];
    int wp[$];
    int wf[$];

    axis_pixel_packer #(
        .DATA_W        (8),
        .BYTES_PER_PIX (2),
        .H_ACTIVE      (4),
        .V_ACTIVE      (2),
        .ADDR_W        (3)
    ) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .S_TDATA    (S_TDATA),
        .S_TVALID   (S_TVALID),
        .S_TREADY   (S_TREADY),
        .S_TLAST    (S_TLAST),
        .S_TUSER    (S_TUSER),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_r       (wr_r),
        .wr_g       (wr_g),
        .wr_b       (wr_b),
        .frame_done (frame_done),
        .line_err   (line_err),
`ifdef PIX_STATS_EN
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt),
`endif
        .sync_lost  (sync_lost)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (wr_valid && wr_ready) begin
            wa.push_back(int'(wr_addr));
            wp.push_back(int'({wr_r, wr_g, wr_b}));
            wf.push_back(int'(frame_done));
        end
        n_fd += int'(frame_done);
        n_le += int'(line_err);
        n_sl += int'(sync_lost);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_acc();
        int n = 0;
        @(negedge CLK);
        while (!S_TREADY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!S_TREADY) chk("accept_timeout", 32'(S_TREADY), 32'd1);
        @(posedge CLK);
        #1;
        S_TVALID = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic u, input logic l);
        S_TDATA  = d;
        S_TUSER  = u;
        S_TLAST  = l;
        S_TVALID = 1'b1;
        wait_acc();
    endtask

    task automatic line(input int n, input logic sof, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < n; i++) begin
            send(b0, sof && i == 0, 1'b0);
            send(b1, 1'b0, i == n - 1);
        end
    endtask

    task automatic clr();
        repeat (3) @(posedge CLK);
        #1;
        wa.delete();
        wp.delete();
        wf.delete();
        n_fd = 0;
        n_le = 0;
        n_sl = 0;
    endtask

    task automatic drain();
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic chk_wr(input string tag, input int e[$]);
        chk({tag, "_count"}, 32'(wa.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < wa.size(); i++)
            chk({tag, "_addr"}, 32'(wa[i]), 32'(e[i]));
    endtask

    initial begin
        int e[$];
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_tready", 32'(S_TREADY), 32'd1);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_outs", 32'({wr_addr, wr_r, wr_g, wr_b}), 32'd0);
        chk("rst_pulses", 32'({frame_done, line_err, sync_lost}), 32'd0);
        RESETn = 1'b1;

        // clean frame: F8 1F -> R=31 G=0 B=31
        clr();
        line(4, 1'b1, 8'hF8, 8'h1F);
        line(4, 1'b0, 8'hF8, 8'h1F);
        drain();
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        chk_wr("clean", e);
        chk("clean_pix0", 32'(wp[0]), 32'hF81F);
        chk("clean_pix7", 32'(wp[7]), 32'hF81F);
        chk("clean_fd_count", 32'(n_fd), 32'd1);
        chk("clean_fd_at7", 32'(wf[7]), 32'd1);
        chk("clean_le", 32'(n_le), 32'd0);

        // back-pressure on pixel (0,0) while byte0 of pixel 1 is offered
        clr();
        wr_ready = 1'b0;
        send(8'hA5, 1'b1, 1'b0);
        send(8'h3C, 1'b0, 1'b0);
        S_TDATA  = 8'h07;
        S_TUSER  = 1'b0;
        S_TLAST  = 1'b0;
        S_TVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_hold", 32'({S_TREADY, wr_valid, wr_addr, wr_r, wr_g, wr_b}), {11'd0, 1'b0, 1'b1, 3'd0, 16'hA53C});
            @(posedge CLK);
            #1;
        end
        wr_ready = 1'b1;
        wait_acc();
        send(8'hE0, 1'b0, 1'b0);
        line(2, 1'b0, 8'hF8, 8'h1F);
        line(4, 1'b0, 8'hF8, 8'h1F);
        drain();
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        chk_wr("bp", e);
        chk("bp_pix0", 32'(wp[0]), 32'hA53C);
        chk("bp_pix1", 32'(wp[1]), 32'h07E0);
        chk("bp_fd_count", 32'(n_fd), 32'd1);

        // short line: TLAST after 3 pixels on line 0
        clr();
        line(3, 1'b1, 8'hF8, 8'h1F);
        line(4, 1'b0, 8'hF8, 8'h1F);
        drain();
        e = '{0, 1, 2, 4, 5, 6, 7};
        chk_wr("short", e);
        chk("short_le", 32'(n_le), 32'd1);
        chk("short_sl", 32'(n_sl), 32'd0);
        chk("short_fd", 32'(n_fd), 32'd1);

        // long line: 6 pixels then TLAST
        clr();
        line(6, 1'b1, 8'h07, 8'hE0);
        line(4, 1'b0, 8'h07, 8'hE0);
        drain();
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        chk_wr("long", e);
        chk("long_pix4", 32'(wp[4]), 32'h07E0);
        chk("long_le", 32'(n_le), 32'd1);
        chk("long_fd", 32'(n_fd), 32'd1);

        // resync: SOF arrives at pixel (2,1)
        clr();
        line(4, 1'b1, 8'hF8, 8'h1F);
        send(8'hF8, 1'b0, 1'b0);
        send(8'h1F, 1'b0, 1'b0);
        send(8'hF8, 1'b0, 1'b0);
        send(8'h1F, 1'b0, 1'b0);
        drain();
        chk("resync_fd_before", 32'(n_fd), 32'd0);
        line(4, 1'b1, 8'hA5, 8'h3C);
        line(4, 1'b0, 8'hA5, 8'h3C);
        drain();
        e = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 6, 7};
        chk_wr("resync", e);
        chk("resync_sl", 32'(n_sl), 32'd1);
        chk("resync_pix6", 32'(wp[6]), 32'hA53C);
        chk("resync_fd", 32'(n_fd), 32'd1);

        // reset with a pending pixel, then headless bytes, then a clean frame
        clr();
        wr_ready = 1'b0;
        send(8'hF8, 1'b1, 1'b0);
        send(8'h1F, 1'b0, 1'b0);
        RESETn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESETn   = 1'b1;
        wr_ready = 1'b1;
        chk("rst_mid_valid", 32'(wr_valid), 32'd0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        drain();
        chk("rst_mid_no_wr", 32'(wa.size()), 32'd0);
        line(4, 1'b1, 8'hF8, 8'h1F);
        line(4, 1'b0, 8'hF8, 8'h1F);
        drain();
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        chk_wr("rst_mid", e);
        chk("rst_mid_fd", 32'(n_fd), 32'd1);
        chk("rst_mid_err", 32'(n_le + n_sl), 32'd0);
`ifdef PIX_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'd1);
        chk("err_cnt", 32'(err_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
